// File: rtl/hazard_sequencer.sv
// Hazard unit: forwarding, load/PC/multiply stalls, flushes,
// multi-cycle multiply sequencing and a saturating stall counter.
module hazard_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  input  logic       ClrCount,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulDoneE,
  output logic [15:0] StallCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 3);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       ldstall;
  logic       pcpend;
  logic       mulstall;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (ra == 4'hF)
      return 2'b00;
    else if (RegWriteM && ra == WA3M)
      return 2'b10;
    else if (RegWriteW && ra == WA3W)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(RA1E);
  assign ForwardBE = fwd_sel(RA2E);

  assign ldstall  = MemtoRegE & RegWriteE &
                    ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcpend   = PCSrcD | PCSrcE | PCSrcM;
  assign mulstall = ((state == IDLE) & MulStartE) | (state == BUSY);

  assign StallF   = ldstall | pcpend | mulstall;
  assign StallD   = ldstall | mulstall;
  assign StallE   = mulstall;
  assign FlushD   = pcpend | PCSrcW | BranchTakenE;
  assign FlushE   = ldstall | BranchTakenE;
  assign FlushM   = mulstall;
  assign MulDoneE = (state == DONE);

  // cnt counts remaining BUSY cycles after the first one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MulStartE) begin
            if (MUL_CYCLES == 2) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0)
            state <= DONE;
          else
            cnt <= cnt - 4'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      StallCount <= 16'd0;
    else if (ClrCount)
      StallCount <= 16'd0;
    else if (StallF && StallCount != 16'hFFFF)
      StallCount <= StallCount + 16'd1;
  end

endmodule
